// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port front end for a 512 x 32 sync RAM.
// One access per four cycles; the granted port gets a one-cycle ack.
module ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    logic   last_grant;
    logic   gnt;
    logic   wr;

    logic              g0;
    logic              g1;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Round-robin pick: a tie goes to the port that did not win last time
    always_comb begin
        g0        = p0_req & (~p1_req | last_grant);
        g1        = p1_req & (~p0_req | ~last_grant);
        sel_write = g1 ? p1_write : p0_write;
        sel_addr  = g1 ? p1_addr  : p0_addr;
        sel_wdata = g1 ? p1_wdata : p0_wdata;
    end

    // Access sequencer: grant, strobe the RAM, capture read data, ack
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            gnt         <= 1'b0;
            wr          <= 1'b0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            busy        <= 1'b0;
        end else begin
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (g0 | g1) begin
                        gnt         <= g1;
                        wr          <= sel_write;
                        last_grant  <= g1;
                        ram_address <= sel_addr;
                        ram_data_in <= sel_wdata;
                        ram_read    <= ~sel_write;
                        ram_write   <= sel_write;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!wr) begin
                        if (gnt) p1_rdata <= ram_data_out;
                        else     p0_rdata <= ram_data_out;
                    end
                    if (gnt) p1_ack <= 1'b1;
                    else     p0_ack <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random accesses against a memory-level
// model of the two-port arbiter and its 512 x 32 synchronous RAM.
module tb_ram_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          p0_req = 1'b0, p0_write = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0, p1_write = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic          ram_read, ram_write, busy;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .clear_n(clear_n),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory-level model: what every word should hold, and what each
    // port's rdata should show (last value it read, 0 after reset)
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] last_rd [2];
    logic [DW-1:0] mem [512];
    logic          preload = 1'b1;

    int passed = 0;
    int total  = 0;

    // Synchronous RAM, 1-cycle registered read
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= ref_mem[i];
        end else begin
            if (ram_write) mem[ram_address] <= ram_data_in;
            if (ram_read) ram_data_out <= mem[ram_address];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int port;
        int cyc;
    } ack_t;
    ack_t ackq[$];

    int            rd_cnt = 0, wr_cnt = 0, dual = 0, busy_cnt = 0;
    int            ack0_cnt = 0, ack1_cnt = 0;
    logic [AW-1:0] strobe_addr = '0;

    // Bus observer sampled mid-cycle
    always @(negedge clock) begin
        if ((p0_ack && p1_ack) || (ram_read && ram_write)) dual <= dual + 1;
        if (ram_read) begin
            rd_cnt      <= rd_cnt + 1;
            strobe_addr <= ram_address;
        end
        if (ram_write) wr_cnt <= wr_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (p0_ack) begin
            ack0_cnt <= ack0_cnt + 1;
            ackq.push_back('{0, cyc});
        end
        if (p1_ack) begin
            ack1_cnt <= ack1_cnt + 1;
            ackq.push_back('{1, cyc});
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            p0_req = r; p0_write = w; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = r; p1_write = w; p1_addr = a; p1_wdata = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? p0_ack : p1_ack;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    // Call at a negedge; returns at the negedge after the ack cycle
    task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit hold,
                          output int lat);
        int            t0;
        bit            got;
        logic [DW-1:0] rd;
        logic [DW-1:0] exp;
        drive(p, 1'b1, w, a, d);
        t0  = cyc;
        got = 0;
        lat = -1;
        rd  = '0;
        exp = w ? last_rd[p] : ref_mem[a];
        if (w) ref_mem[a] = d;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (ack_of(p)) begin
                got = 1;
                rd  = rdata_of(p);
                lat = cyc - t0;
                chk($sformatf("p%0d_other_ack", p), {31'b0, ack_of(1 - p)}, 0);
            end
        end
        chk($sformatf("p%0d_ack_seen", p), {31'b0, got}, 1);
        chk($sformatf("p%0d_rdata_a%0d", p, a), rd, exp);
        last_rd[p] = exp;
        if (!hold) drive(p, 1'b0, w, a, d);
        @(negedge clock);
        chk($sformatf("p%0d_ack_pulse", p), {31'b0, ack_of(p)}, 0);
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clock);
        clear_n    = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    int            lat, b0, r0, w0, a0, q0;
    logic [AW-1:0] ca [4];

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = $urandom;
        ref_mem[149] = 32'h000000FF;
        ref_mem[0]   = 32'h01800095;
        ref_mem[135] = 32'h10800087;
        ref_mem[83]  = 32'h69A00053;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clock);
        preload = 1'b0;

        chk("reset_ctl", {27'b0, p0_ack, p1_ack, ram_read, ram_write, busy}, 0);
        chk("reset_addr", {23'b0, ram_address}, 0);
        chk("reset_wdata", ram_data_in, 0);
        chk("reset_p0_rdata", p0_rdata, 0);
        chk("reset_p1_rdata", p1_rdata, 0);
        clear_n = 1'b1;
        @(negedge clock);

        // Single read of a preloaded word
        r0 = rd_cnt; a0 = ack1_cnt; b0 = busy_cnt;
        access(0, 1'b0, 9'd149, '0, 0, lat);
        chk("rd149_latency", lat, 3);
        #1;
        chk("rd149_strobes", rd_cnt - r0, 1);
        chk("rd149_addr", {23'b0, strobe_addr}, 149);
        chk("rd149_p1_quiet", ack1_cnt - a0, 0);
        chk("rd149_busy_cycles", busy_cnt - b0, 3);
        @(negedge clock);

        // Write from p1, read back on p0
        w0 = wr_cnt;
        access(1, 1'b1, 9'd20, 32'hDEADBEEF, 0, lat);
        #1;
        chk("wr20_strobes", wr_cnt - w0, 1);
        @(negedge clock);
        access(0, 1'b0, 9'd20, '0, 0, lat);

        // Continuous contention straight out of reset
        do_reset();
        for (int k = 0; k < 4; k++) ca[k] = AW'(300 + 40 * k + $urandom_range(0, 39));
        q0 = ackq.size();
        fork
            begin
                int l;
                access(0, 1'b0, ca[0], '0, 1, l);
                access(0, 1'b0, ca[2], '0, 0, l);
            end
            begin
                int l;
                access(1, 1'b0, ca[1], '0, 1, l);
                access(1, 1'b0, ca[3], '0, 0, l);
            end
        join
        #1;
        chk("rr_ack_count", ackq.size() - q0, 4);
        if (ackq.size() - q0 == 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("rr_order%0d", k), ackq[q0 + k].port, k % 2);
            for (int k = 1; k < 4; k++)
                chk($sformatf("rr_space%0d", k),
                    ackq[q0 + k].cyc - ackq[q0 + k - 1].cyc, 4);
        end
        @(negedge clock);

        // Lone requester back-to-back
        q0 = ackq.size();
        access(1, 1'b0, 9'd0, '0, 0, lat);
        chk("b2b_lat0", lat, 3);
        access(1, 1'b0, 9'd135, '0, 0, lat);
        chk("b2b_lat1", lat, 3);
        access(1, 1'b0, 9'd83, '0, 0, lat);
        chk("b2b_lat2", lat, 3);
        #1;
        chk("b2b_count", ackq.size() - q0, 3);
        if (ackq.size() - q0 == 3) begin
            for (int k = 1; k < 3; k++)
                chk($sformatf("b2b_space%0d", k),
                    ackq[q0 + k].cyc - ackq[q0 + k - 1].cyc, 4);
        end
        chk("b2b_last_rdata", p1_rdata, 32'h69A00053);
        @(negedge clock);

        // Reset during ISSUE aborts the write
        a0 = ack0_cnt;
        drive(0, 1'b1, 1'b1, 9'd5, 32'hA5A50000);
        @(posedge clock);
        #1;
        chk("abort_wr_strobe", {31'b0, ram_write}, 1);
        chk("abort_busy", {31'b0, busy}, 1);
        #2;
        clear_n = 1'b0;
        #1;
        chk("abort_strobes_off", {30'b0, ram_read, ram_write}, 0);
        chk("abort_busy_off", {31'b0, busy}, 0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        clear_n    = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (6) @(negedge clock);
        #1;
        chk("abort_no_ack", ack0_cnt - a0, 0);
        @(negedge clock);
        access(0, 1'b0, 9'd5, '0, 0, lat);
        chk("abort_rd_lat", lat, 3);

        // Idle stretch
        r0 = rd_cnt; w0 = wr_cnt; b0 = busy_cnt;
        repeat (10) @(negedge clock);
        #1;
        chk("idle_quiet", (rd_cnt - r0) + (wr_cnt - w0) + (busy_cnt - b0), 0);
        @(negedge clock);

        // Random single accesses against the memory model
        for (int n = 0; n < 24; n++) begin
            int            p;
            logic          w;
            logic [AW-1:0] a;
            p = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 511));
            access(p, w, a, $urandom, 0, lat);
            chk($sformatf("rnd%0d_lat", n), lat, 3);
        end

        #1;
        chk("never_dual", dual, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
